// File: rtl/stream_buffer_pkg.sv
// Sizing helpers shared by the width-converting stream buffer and its unit RAM.
// A storage unit is the narrower of the two bus widths.
package stream_buffer_pkg;

    function automatic int unsigned unit_width(int unsigned rw, int unsigned ww);
        return (rw < ww) ? rw : ww;
    endfunction

    function automatic int unsigned units_per_write(int unsigned rw, int unsigned ww);
        return ww / unit_width(rw, ww);
    endfunction

    function automatic int unsigned units_per_read(int unsigned rw, int unsigned ww);
        return rw / unit_width(rw, ww);
    endfunction

    function automatic int unsigned pad_max(int unsigned rw, int unsigned ww);
        int unsigned wpw;
        int unsigned rpr;
        wpw = units_per_write(rw, ww);
        rpr = units_per_read(rw, ww);
        return (rpr > wpw) ? rpr - wpw : 0;
    endfunction

    function automatic int unsigned cap_units(int unsigned depth, int unsigned rw,
                                              int unsigned ww);
        int unsigned wpw;
        int unsigned rpr;
        wpw = units_per_write(rw, ww);
        rpr = units_per_read(rw, ww);
        return 1 << $clog2(depth * ((wpw > rpr) ? wpw : rpr));
    endfunction

    function automatic int unsigned ptr_width(int unsigned cap);
        return ($clog2(cap) > 0) ? $clog2(cap) : 1;
    endfunction

    function automatic int unsigned cnt_width(int unsigned cap);
        return $clog2(cap) + 1;
    endfunction

    // Wide enough to hold wr_phase + units_per_write without overflow.
    function automatic int unsigned phase_width(int unsigned rw, int unsigned ww);
        return $clog2(units_per_read(rw, ww) + units_per_write(rw, ww) + 1);
    endfunction

endpackage

// File: rtl/stream_buffer_unit_ram.sv
// Unit-addressed storage: LANES write lanes with per-lane enable and RPR combinational
// read lanes, modular addressing, plus a parallel packet-end flag per unit.
module stream_buffer_unit_ram
    import stream_buffer_pkg::*;
#(
    parameter int unsigned G     = 32,
    parameter int unsigned CAP   = 8,
    parameter int unsigned LANES = 2,
    parameter int unsigned RPR   = 2,
    localparam int unsigned AW   = ptr_width(CAP)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        i_wr_ptr,
    input  logic [LANES-1:0]     i_wr_en,
    input  logic [LANES*G-1:0]   i_wr_data,
    input  logic [LANES-1:0]     i_wr_last,
    input  logic [AW-1:0]        i_rd_ptr,
    output logic [RPR*G-1:0]     o_rd_data,
    output logic                 o_rd_last
);

    logic [G-1:0]   r_mem [CAP];
    logic [CAP-1:0] r_flag;

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < LANES; k++) begin
            if (i_wr_en[k]) begin
                r_mem[i_wr_ptr + AW'(k)] <= i_wr_data[k*G +: G];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flag <= '0;
        end else begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (i_wr_en[k]) begin
                    r_flag[i_wr_ptr + AW'(k)] <= i_wr_last[k];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < RPR; k++) begin
            o_rd_data[k*G +: G] = r_mem[i_rd_ptr + AW'(k)];
        end
        o_rd_last = r_flag[i_rd_ptr + AW'(RPR - 1)];
    end

endmodule

// File: rtl/stream_width_buffer.sv
// Width-converting stream FIFO with packet framing and zero-padding of partial read words.
// Define STREAM_WIDTH_BUFFER_OCCUPANCY_EN to expose the unit count on an occupancy port.
module stream_width_buffer
    import stream_buffer_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned READ_WIDTH  = 64,
    parameter int unsigned WRITE_WIDTH = 32,
    localparam int unsigned CAP        = cap_units(DEPTH, READ_WIDTH, WRITE_WIDTH),
    localparam int unsigned CW         = cnt_width(CAP)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WRITE_WIDTH-1:0] w_data,
    input  logic                   w_valid,
    input  logic                   w_last,
    output logic                   w_ready,
    output logic                   w_almost_full,
    output logic [READ_WIDTH-1:0]  r_data,
    output logic                   r_valid,
    output logic                   r_last,
    input  logic                   r_ready
`ifdef STREAM_WIDTH_BUFFER_OCCUPANCY_EN
    ,
    output logic [CW-1:0]          occupancy
`endif
);

    localparam int unsigned G      = unit_width(READ_WIDTH, WRITE_WIDTH);
    localparam int unsigned WPW    = units_per_write(READ_WIDTH, WRITE_WIDTH);
    localparam int unsigned RPR    = units_per_read(READ_WIDTH, WRITE_WIDTH);
    localparam int unsigned PADMAX = pad_max(READ_WIDTH, WRITE_WIDTH);
    localparam int unsigned LANES  = WPW + PADMAX;
    localparam int unsigned AW     = ptr_width(CAP);
    localparam int unsigned PW     = phase_width(READ_WIDTH, WRITE_WIDTH);

    if (((READ_WIDTH > WRITE_WIDTH) ? (READ_WIDTH % WRITE_WIDTH)
                                    : (WRITE_WIDTH % READ_WIDTH)) != 0) begin : g_chk_ratio
        $error("stream_width_buffer: wider bus must be a multiple of the narrower one");
    end
    if (CAP < LANES) begin : g_chk_cap_write
        $error("stream_width_buffer: capacity too small for a padded write");
    end
    if (CAP < RPR) begin : g_chk_cap_read
        $error("stream_width_buffer: capacity too small for one read word");
    end

    logic [AW-1:0]      r_w_ptr;
    logic [AW-1:0]      r_r_ptr;
    logic [CW-1:0]      r_count;
    logic [PW-1:0]      r_wr_phase;
    logic               r_almost_full;

    logic               w_accept;
    logic               w_rd_fire;
    logic [PW-1:0]      w_phase_sum;
    logic [PW-1:0]      w_rem;
    logic [PW-1:0]      w_pad;
    logic [PW-1:0]      w_phase_next;
    logic [CW-1:0]      w_added;
    logic [CW-1:0]      w_removed;
    logic [CW-1:0]      w_count_next;
    logic [CW-1:0]      w_free_next;
    logic [LANES-1:0]   w_lane_en;
    logic [LANES-1:0]   w_lane_last;
    logic [LANES*G-1:0] w_lane_data;
    logic [RPR*G-1:0]   w_rd_data;
    logic               w_rd_last;

    // Space is reserved for the worst-case padded write so w_ready never depends on w_last.
    assign w_ready   = (CW'(CAP) - r_count) >= CW'(LANES);
    assign r_valid   = r_count >= CW'(RPR);
    assign w_accept  = w_valid && w_ready;
    assign w_rd_fire = r_valid && r_ready;

    always_comb begin
        w_phase_sum  = r_wr_phase + PW'(WPW);
        w_rem        = w_phase_sum % PW'(RPR);
        w_pad        = '0;
        if (w_last && (w_rem != '0)) begin
            w_pad = PW'(RPR) - w_rem;
        end
        w_phase_next = w_last ? '0 : w_rem;
        w_added      = w_accept ? (CW'(WPW) + CW'(w_pad)) : '0;
        w_removed    = w_rd_fire ? CW'(RPR) : '0;
        w_count_next = r_count + w_added - w_removed;
        w_free_next  = CW'(CAP) - w_count_next;

        for (int unsigned k = 0; k < WPW; k++) begin
            w_lane_en[k]          = w_accept;
            w_lane_data[k*G +: G] = w_data[k*G +: G];
        end
        for (int unsigned k = WPW; k < LANES; k++) begin
            w_lane_en[k]          = w_accept && (PW'(k - WPW) < w_pad);
            w_lane_data[k*G +: G] = '0;
        end
        for (int unsigned k = 0; k < LANES; k++) begin
            w_lane_last[k] = w_last && (PW'(k) == (PW'(WPW) + w_pad - PW'(1)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_w_ptr       <= '0;
            r_r_ptr       <= '0;
            r_count       <= '0;
            r_wr_phase    <= '0;
            r_almost_full <= 1'b0;
        end else begin
            if (w_accept) begin
                r_w_ptr    <= r_w_ptr + w_added[AW-1:0];
                r_wr_phase <= w_phase_next;
            end
            if (w_rd_fire) begin
                r_r_ptr <= r_r_ptr + AW'(RPR);
            end
            r_count       <= w_count_next;
            r_almost_full <= 32'(w_free_next) < 32'(2 * LANES);
        end
    end

    stream_buffer_unit_ram #(
        .G     (G),
        .CAP   (CAP),
        .LANES (LANES),
        .RPR   (RPR)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_ptr  (r_w_ptr),
        .i_wr_en   (w_lane_en),
        .i_wr_data (w_lane_data),
        .i_wr_last (w_lane_last),
        .i_rd_ptr  (r_r_ptr),
        .o_rd_data (w_rd_data),
        .o_rd_last (w_rd_last)
    );

    assign w_almost_full = r_almost_full;
    assign r_data        = r_valid ? w_rd_data : '0;
    assign r_last        = r_valid && w_rd_last;

`ifdef STREAM_WIDTH_BUFFER_OCCUPANCY_EN
    assign occupancy = r_count;
`endif

endmodule

// File: tb/tb_stream_width_buffer.sv
// Directed bench: a 32->64 instance (CAP=8) and a 64->16 instance (CAP=16).
module tb_stream_width_buffer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] a_w_data;
    logic        a_w_valid, a_w_last, a_w_ready, a_w_af;
    logic [63:0] a_r_data;
    logic        a_r_valid, a_r_last, a_r_ready;

    logic [63:0] b_w_data;
    logic        b_w_valid, b_w_last, b_w_ready, b_w_af;
    logic [15:0] b_r_data;
    logic        b_r_valid, b_r_last, b_r_ready;

`ifdef STREAM_WIDTH_BUFFER_OCCUPANCY_EN
    logic [3:0] a_occ;
    logic [4:0] b_occ;
`endif

    stream_width_buffer #(.DEPTH(4), .READ_WIDTH(64), .WRITE_WIDTH(32)) u_a (
        .clk           (clk),
        .rst           (rst),
        .w_data        (a_w_data),
        .w_valid       (a_w_valid),
        .w_last        (a_w_last),
        .w_ready       (a_w_ready),
        .w_almost_full (a_w_af),
        .r_data        (a_r_data),
        .r_valid       (a_r_valid),
        .r_last        (a_r_last),
        .r_ready       (a_r_ready)
`ifdef STREAM_WIDTH_BUFFER_OCCUPANCY_EN
        ,
        .occupancy     (a_occ)
`endif
    );

    stream_width_buffer #(.DEPTH(4), .READ_WIDTH(16), .WRITE_WIDTH(64)) u_b (
        .clk           (clk),
        .rst           (rst),
        .w_data        (b_w_data),
        .w_valid       (b_w_valid),
        .w_last        (b_w_last),
        .w_ready       (b_w_ready),
        .w_almost_full (b_w_af),
        .r_data        (b_r_data),
        .r_valid       (b_r_valid),
        .r_last        (b_r_last),
        .r_ready       (b_r_ready)
`ifdef STREAM_WIDTH_BUFFER_OCCUPANCY_EN
        ,
        .occupancy     (b_occ)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] b_exp [4];
    int          rd_idx;

    initial begin
        a_w_data = '0; a_w_valid = 0; a_w_last = 0; a_r_ready = 0;
        b_w_data = '0; b_w_valid = 0; b_w_last = 0; b_r_ready = 0;
        tick();
        tick();
        rst = 1'b1;

        // Reset state
        check_eq("rst_a_rvalid", 64'(a_r_valid), 64'd0);
        check_eq("rst_a_rlast",  64'(a_r_last),  64'd0);
        check_eq("rst_a_rdata",  a_r_data,       64'd0);
        check_eq("rst_a_wready", 64'(a_w_ready), 64'd1);
        check_eq("rst_a_af",     64'(a_w_af),    64'd0);
        check_eq("rst_b_wready", 64'(b_w_ready), 64'd1);
        check_eq("rst_b_rvalid", 64'(b_r_valid), 64'd0);

        // 1: two narrow writes pack into one wide word, low half first
        a_w_valid = 1; a_w_data = 32'hAAAA_AAAA;
        tick();
        check_eq("t1_half_rvalid", 64'(a_r_valid), 64'd0);
        a_w_data = 32'hBBBB_BBBB;
        tick();
        a_w_valid = 0;
        check_eq("t1_rvalid", 64'(a_r_valid), 64'd1);
        check_eq("t1_rdata",  a_r_data,       64'hBBBB_BBBB_AAAA_AAAA);
        check_eq("t1_rlast",  64'(a_r_last),  64'd0);
        a_r_ready = 1;
        tick();
        a_r_ready = 0;
        check_eq("t1_drained", 64'(a_r_valid), 64'd0);

        // 2: a lone packet-end write is zero-padded to a full word
        a_w_valid = 1; a_w_data = 32'hCCCC_CCCC; a_w_last = 1;
        tick();
        a_w_valid = 0; a_w_last = 0;
        check_eq("t2_rdata", a_r_data,             64'h0000_0000_CCCC_CCCC);
        check_eq("t2_rlast", 64'(a_r_last),        64'd1);
        check_eq("t2_count", 64'(u_a.r_count),     64'd2);
        a_r_ready = 1;
        tick();
        a_r_ready = 0;
        check_eq("t2_count0", 64'(u_a.r_count), 64'd0);

        // 3: one wide write splits into four narrow reads
        b_exp[0] = 16'h1111; b_exp[1] = 16'h2222; b_exp[2] = 16'h3333; b_exp[3] = 16'h4444;
        b_w_valid = 1; b_w_last = 1; b_w_data = 64'h4444_3333_2222_1111; b_r_ready = 1;
        tick();
        b_w_valid = 0; b_w_last = 0;
        for (int i = 0; i < 4; i++) begin
            check_eq("t3_rvalid", 64'(b_r_valid), 64'd1);
            check_eq("t3_rdata",  64'(b_r_data),  64'(b_exp[i]));
            check_eq("t3_rlast",  64'(b_r_last),  (i == 3) ? 64'd1 : 64'd0);
            tick();
        end
        b_r_ready = 0;
        check_eq("t3_empty", 64'(b_r_valid), 64'd0);

        // 4: fill with padded packet-end writes, backpressure, then read/write together
        a_w_last = 1;
        for (int i = 0; i < 4; i++) begin
            a_w_valid = 1; a_w_data = 32'h4000_0000 + 32'(i);
            tick();
            if (i == 1) begin
                check_eq("t4_af_at4", 64'(a_w_af),      64'd0);
                check_eq("t4_count4", 64'(u_a.r_count), 64'd4);
            end
            if (i == 2) begin
                check_eq("t4_count6", 64'(u_a.r_count), 64'd6);
                check_eq("t4_wready6", 64'(a_w_ready),  64'd1);
                check_eq("t4_af6",    64'(a_w_af),      64'd1);
            end
            if (i == 3) begin
                check_eq("t4_count8", 64'(u_a.r_count), 64'd8);
                check_eq("t4_wready8", 64'(a_w_ready),  64'd0);
            end
        end
        a_w_data = 32'hDEAD_BEEF;
        tick();
        a_w_valid = 0;
        check_eq("t4_ignored", 64'(u_a.r_count), 64'd8);
        a_r_ready = 1;
        check_eq("t4_rd0", a_r_data, 64'h0000_0000_4000_0000);
        check_eq("t4_rl0", 64'(a_r_last), 64'd1);
        tick();
        a_r_ready = 0;
        check_eq("t4_count_after_rd", 64'(u_a.r_count), 64'd6);
        check_eq("t4_wready_after_rd", 64'(a_w_ready),  64'd1);
        a_w_valid = 1; a_w_data = 32'h4000_0004; a_r_ready = 1;
        check_eq("t4_rd1", a_r_data, 64'h0000_0000_4000_0001);
        tick();
        a_w_valid = 0; a_r_ready = 0;
        check_eq("t4_count_simul", 64'(u_a.r_count), 64'd6);
        a_r_ready = 1;
        for (int i = 2; i < 5; i++) begin
            check_eq("t4_drain", a_r_data, {32'h0, 32'h4000_0000 + 32'(i)});
            check_eq("t4_drain_last", 64'(a_r_last), 64'd1);
            tick();
        end
        a_r_ready = 0; a_w_last = 0;
        check_eq("t4_empty", 64'(u_a.r_count), 64'd0);

        // 5: streaming across several pointer wraps
        rd_idx = 0;
        a_r_ready = 1;
        for (int i = 0; i < 48; i++) begin
            a_w_valid = (i < 40);
            a_w_data  = 32'(i);
            if (a_r_valid) begin
                check_eq("t5_word", a_r_data, {32'(2 * rd_idx + 1), 32'(2 * rd_idx)});
                rd_idx++;
            end
            tick();
        end
        a_w_valid = 0; a_r_ready = 0;
        check_eq("t5_nwords", 64'(rd_idx), 64'd20);

        // 6: reset with data and a packet-end flag pending
        a_w_valid = 1; a_w_last = 1; a_w_data = 32'h6000_0000;
        tick();
        a_w_last = 0;
        for (int i = 1; i < 4; i++) begin
            a_w_data = 32'h6000_0000 + 32'(i);
            tick();
        end
        a_w_valid = 0;
        check_eq("t6_count5", 64'(u_a.r_count), 64'd5);
        check_eq("t6_pre_rlast", 64'(a_r_last), 64'd1);
        check_eq("t6_pre_af", 64'(a_w_af), 64'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_eq("t6_rvalid", 64'(a_r_valid), 64'd0);
        check_eq("t6_rlast",  64'(a_r_last),  64'd0);
        check_eq("t6_rdata",  a_r_data,       64'd0);
        check_eq("t6_wready", 64'(a_w_ready), 64'd1);
        check_eq("t6_af",     64'(a_w_af),    64'd0);
        a_w_valid = 1; a_w_data = 32'h7000_0000;
        tick();
        a_w_data = 32'h7000_0001;
        tick();
        a_w_valid = 0;
        check_eq("t6_rdata_after", a_r_data, 64'h7000_0001_7000_0000);
        check_eq("t6_rlast_after", 64'(a_r_last), 64'd0);
        a_r_ready = 1;
        tick();
        a_r_ready = 0;
        check_eq("t6_final_empty", 64'(a_r_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
